// File: rtl/d_sa_cache_ctrl.sv
// 4-set x 4-way write-back/write-allocate data cache controller; hit 2 cycles, clean miss 7, dirty miss 11.
// Backpressure: one request at a time (cpu_ready only in RESP); each memory beat holds until mem_ack.
module d_sa_lookup #(
    parameter int TAG_W = 28
) (
    input  logic               in_req,
    input  logic [1:0]         in_set,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic [4*TAG_W-1:0] way_tag,
    input  logic [3:0]         way_valid,
    output logic               hit,
    output logic [3:0]         set_cache_line_no
);
    always_comb begin
        hit               = 1'b0;
        set_cache_line_no = {in_set, 2'b00};
        for (int w = 0; w < 4; w++) begin
            if (in_req && !hit && way_valid[w] && (way_tag[w*TAG_W +: TAG_W] == in_tag)) begin
                hit               = 1'b1;
                set_cache_line_no = {in_set, 2'(w)};
            end
        end
    end
endmodule

module d_sa_cache_ctrl #(
    parameter int TAG_W  = 28,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);
    typedef enum logic [2:0] {IDLE, LOOKUP, WB, REFILL, RESP} state_t;

    state_t            state;
    logic [TAG_W-1:0]  tag_arr  [16];
    logic [DATA_W-1:0] data_arr [16][4];
    logic [15:0]       valid;
    logic [15:0]       dirty;
    logic [1:0]        rr [4];

    logic [31:0]       req_addr;
    logic              req_we;
    logic [DATA_W-1:0] req_wdata;
    logic [3:0]        victim;
    logic              vic_rr;
    logic [1:0]        beat;

    logic [TAG_W-1:0]  req_tag;
    logic [1:0]        req_set;
    logic [1:0]        req_word;
    logic [1:0]        next_beat;
    logic [4*TAG_W-1:0] set_tags;
    logic [3:0]        set_valid;
    logic              hit;
    logic [3:0]        hit_line;
    logic [1:0]        vic_way;
    logic              vic_from_rr;
    logic [3:0]        vic_line;

    assign req_tag   = req_addr[31 -: TAG_W];
    assign req_set   = req_addr[3:2];
    assign req_word  = req_addr[1:0];
    assign next_beat = beat + 2'd1;
    assign vic_line  = {req_set, vic_way};

    always_comb begin
        set_tags  = '0;
        set_valid = '0;
        for (int w = 0; w < 4; w++) begin
            set_tags[w*TAG_W +: TAG_W] = tag_arr[{req_set, 2'(w)}];
            set_valid[w]               = valid[{req_set, 2'(w)}];
        end
    end

    d_sa_lookup #(.TAG_W(TAG_W)) u_lookup (
        .in_req            (state == LOOKUP),
        .in_set            (req_set),
        .in_tag            (req_tag),
        .way_tag           (set_tags),
        .way_valid         (set_valid),
        .hit               (hit),
        .set_cache_line_no (hit_line)
    );

    // Lowest invalid way wins; round-robin only when the whole set is valid.
    always_comb begin
        vic_way     = rr[req_set];
        vic_from_rr = 1'b1;
        for (int w = 3; w >= 0; w--) begin
            if (!set_valid[w]) begin
                vic_way     = 2'(w);
                vic_from_rr = 1'b0;
            end
        end
    end

    // Tag and data storage carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (state == LOOKUP && hit && req_we)
            data_arr[hit_line][req_word] <= req_wdata;
        if (state == REFILL && mem_ack) begin
            data_arr[victim][beat] <= mem_rdata;
            if (beat == 2'd3)
                tag_arr[victim] <= req_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            valid     <= '0;
            dirty     <= '0;
            for (int s = 0; s < 4; s++) rr[s] <= 2'd0;
            req_addr  <= '0;
            req_we    <= 1'b0;
            req_wdata <= '0;
            victim    <= '0;
            vic_rr    <= 1'b0;
            beat      <= '0;
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cpu_ready <= 1'b0;
                    if (cpu_req) begin
                        req_addr  <= cpu_addr;
                        req_we    <= cpu_we;
                        req_wdata <= cpu_wdata;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        if (req_we) dirty[hit_line] <= 1'b1;
                        else        cpu_rdata       <= data_arr[hit_line][req_word];
                        cpu_ready <= 1'b1;
                        state     <= RESP;
                    end else begin
                        victim  <= vic_line;
                        vic_rr  <= vic_from_rr;
                        beat    <= 2'd0;
                        mem_req <= 1'b1;
                        if (valid[vic_line] && dirty[vic_line]) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= {tag_arr[vic_line], req_set, 2'b00};
                            mem_wdata <= data_arr[vic_line][0];
                            state     <= WB;
                        end else begin
                            mem_we   <= 1'b0;
                            mem_addr <= {req_tag, req_set, 2'b00};
                            state    <= REFILL;
                        end
                    end
                end
                WB: begin
                    if (mem_ack) begin
                        beat <= next_beat;
                        if (beat == 2'd3) begin
                            mem_we   <= 1'b0;
                            mem_addr <= {req_tag, req_set, 2'b00};
                            state    <= REFILL;
                        end else begin
                            mem_addr  <= {tag_arr[victim], req_set, next_beat};
                            mem_wdata <= data_arr[victim][next_beat];
                        end
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        beat <= next_beat;
                        if (beat == 2'd3) begin
                            mem_req       <= 1'b0;
                            valid[victim] <= 1'b1;
                            dirty[victim] <= 1'b0;
                            if (vic_rr) rr[req_set] <= rr[req_set] + 2'd1;
                            state <= LOOKUP;
                        end else begin
                            mem_addr <= {req_tag, req_set, next_beat};
                        end
                    end
                end
                RESP: begin
                    cpu_ready <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_d_sa_cache_ctrl.sv
// Directed-vector bench for d_sa_cache_ctrl with a behavioural word memory that acks after a set delay.
module tb_d_sa_cache_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;

    d_sa_cache_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        chk_rd;
        logic [31:0] rdata;
        int          beats;
        logic [3:0]  vmask;
        logic [3:0]  dmask;
        logic [1:0]  rr1;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    int          errors = 0;
    int          checks = 0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          req_cyc = 0;
    int          stab_err = 0;
    logic        prev_pend = 1'b0;
    logic [31:0] p_addr, p_wdata;
    logic        p_we;
    beat_t       blog[$];
    logic [31:0] mem_store[logic [31:0]];

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return 32'h5A00_0000 ^ a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: decides mem_ack for the next edge, logs each beat and watches request stability.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                req_cyc++;
                if (prev_pend && (mem_addr !== p_addr || mem_we !== p_we || (mem_we && mem_wdata !== p_wdata)))
                    stab_err++;
                if (wait_cnt >= ack_delay) begin
                    mem_ack  = 1'b1;
                    wait_cnt = 0;
                    if (mem_we) begin
                        mem_store[mem_addr] = mem_wdata;
                        mem_rdata = '0;
                        blog.push_back('{1'b1, mem_addr, mem_wdata});
                    end else begin
                        mem_rdata = mem_val(mem_addr);
                        blog.push_back('{1'b0, mem_addr, mem_rdata});
                    end
                end else begin
                    mem_ack = 1'b0;
                    wait_cnt++;
                end
                prev_pend = !mem_ack;
                p_addr    = mem_addr;
                p_wdata   = mem_wdata;
                p_we      = mem_we;
            end else begin
                mem_ack   = 1'b0;
                wait_cnt  = 0;
                prev_pend = 1'b0;
            end
        end
    end

    // Called #1 after an edge with the controller idle; returns at #1 after the completing edge.
    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd);
        blog.delete();
        req_cyc   = 0;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = wd;
        cpu_req   = 1'b1;
        lat = 0;
        while (lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
            if (cpu_ready) break;
        end
        rd = cpu_rdata;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
    endtask

    vec_t        vecs[10];
    logic [31:0] exp_wb[4];
    int          lat;
    logic [31:0] rd;
    logic [31:0] base;
    int          bad;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal;
    end

    initial begin
        //              we    addr          wdata         lat chk rdata          beats vmask    dmask    rr1
        vecs[0] = '{1'b0, 32'h14, 32'h0,        7,  1'b1, 32'h5A00_0014, 4, 4'b0001, 4'b0000, 2'd0};
        vecs[1] = '{1'b1, 32'h15, 32'hDEADBEEF, 2,  1'b0, 32'h0,         0, 4'b0001, 4'b0001, 2'd0};
        vecs[2] = '{1'b0, 32'h15, 32'h0,        2,  1'b1, 32'hDEADBEEF,  0, 4'b0001, 4'b0001, 2'd0};
        vecs[3] = '{1'b0, 32'h24, 32'h0,        7,  1'b1, 32'h5A00_0024, 4, 4'b0011, 4'b0001, 2'd0};
        vecs[4] = '{1'b0, 32'h34, 32'h0,        7,  1'b1, 32'h5A00_0034, 4, 4'b0111, 4'b0001, 2'd0};
        vecs[5] = '{1'b0, 32'h44, 32'h0,        7,  1'b1, 32'h5A00_0044, 4, 4'b1111, 4'b0001, 2'd0};
        vecs[6] = '{1'b0, 32'h54, 32'h0,        11, 1'b1, 32'h5A00_0054, 8, 4'b1111, 4'b0000, 2'd1};
        vecs[7] = '{1'b0, 32'h15, 32'h0,        7,  1'b1, 32'hDEADBEEF,  4, 4'b1111, 4'b0000, 2'd2};
        vecs[8] = '{1'b0, 32'h24, 32'h0,        7,  1'b1, 32'h5A00_0024, 4, 4'b1111, 4'b0000, 2'd3};
        vecs[9] = '{1'b0, 32'h44, 32'h0,        2,  1'b1, 32'h5A00_0044, 0, 4'b1111, 4'b0000, 2'd3};
        exp_wb[0] = 32'h5A00_0014;
        exp_wb[1] = 32'hDEADBEEF;
        exp_wb[2] = 32'h5A00_0016;
        exp_wb[3] = 32'h5A00_0017;

        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        #22;
        check("reset cpu_ready", 32'(cpu_ready), 32'h0);
        check("reset cpu_rdata", cpu_rdata, 32'h0);
        check("reset mem_req",   32'(mem_req), 32'h0);
        check("reset mem_addr",  mem_addr, 32'h0);
        check("reset valid",     32'(dut.valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd);
            check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            if (vecs[i].chk_rd) check($sformatf("v%0d rdata", i), rd, vecs[i].rdata);
            check($sformatf("v%0d beats", i), 32'(blog.size()), 32'(vecs[i].beats));
            check($sformatf("v%0d mem_req cycles", i), 32'(req_cyc), 32'(vecs[i].beats));
            check($sformatf("v%0d ready pulse", i), 32'(cpu_ready), 32'h0);
            check($sformatf("v%0d valid set1", i), 32'(dut.valid[7:4]), 32'(vecs[i].vmask));
            check($sformatf("v%0d dirty set1", i), 32'(dut.dirty[7:4]), 32'(vecs[i].dmask));
            check($sformatf("v%0d rr1", i), 32'(dut.rr[1]), 32'(vecs[i].rr1));
            if (vecs[i].beats == 8) begin
                bad = 0;
                for (int k = 0; k < 4; k++)
                    if (blog[k].we !== 1'b1 || blog[k].addr !== 32'h14 + k || blog[k].data !== exp_wb[k]) bad++;
                check($sformatf("v%0d writeback beats", i), 32'(bad), 32'h0);
            end
            if (vecs[i].beats >= 4) begin
                bad  = 0;
                base = {vecs[i].addr[31:2], 2'b00};
                for (int k = 0; k < 4; k++)
                    if (blog[blog.size()-4+k].we !== 1'b0 || blog[blog.size()-4+k].addr !== base + k) bad++;
                check($sformatf("v%0d refill beats", i), 32'(bad), 32'h0);
            end
        end

        // Slow memory: 3 wait cycles per beat on a clean miss evicting way 3.
        ack_delay = 3;
        stab_err  = 0;
        do_req(1'b0, 32'h64, 32'h0, lat, rd);
        check("slow latency", 32'(lat), 32'd19);
        check("slow rdata", rd, 32'h5A00_0064);
        check("slow beats", 32'(blog.size()), 32'd4);
        check("slow stability", 32'(stab_err), 32'h0);
        check("slow rr1 wrap", 32'(dut.rr[1]), 32'h0);

        // Reset after beat 2 of a refill.
        ack_delay = 0;
        blog.delete();
        cpu_we = 1'b0; cpu_addr = 32'h74; cpu_req = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            #1;
            if (blog.size() >= 3) break;
        end
        check("pre-reset beats", 32'(blog.size()), 32'd3);
        @(posedge clk);
        #2;
        rst_n   = 1'b0;
        cpu_req = 1'b0;
        #1;
        check("reset drops mem_req", 32'(mem_req), 32'h0);
        check("reset valid clear", 32'(dut.valid), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_req(1'b0, 32'h74, 32'h0, lat, rd);
        check("post-reset latency", 32'(lat), 32'd7);
        check("post-reset beats", 32'(blog.size()), 32'd4);
        check("post-reset rdata", rd, 32'h5A00_0074);
        check("post-reset valid set1", 32'(dut.valid[7:4]), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
